// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        StIdle,
        StShift
    } piso_state_e;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with valid/ready load, per-word bit order,
// bit-rate enable and a one-cycle done pulse.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic             msb_first,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        order_d  = order_q;
        last_bit = (state_q == StShift) && shift_en && (cnt_q == CNT_LAST);
        done_d   = last_bit;

        load_ready = (state_q == StIdle) || last_bit;
        accept     = load_valid && load_ready;

        // A same-cycle accept overrides the last-bit return to idle (no gap).
        if (accept) begin
            sreg_d  = p_in;
            order_d = msb_first;
            cnt_d   = '0;
            state_d = StShift;
        end else if ((state_q == StShift) && shift_en) begin
            if (order_q == ORDER_MSB) begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
            if (last_bit) begin
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_LSB;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        s_valid = (state_q == StShift);
        busy    = (state_q == StShift);
        done    = done_q;
        if (state_q == StShift) begin
            s_out = (order_q == ORDER_MSB) ? sreg_q[WIDTH-1] : sreg_q[0];
        end else begin
            s_out = 1'b0;
        end
    end

endmodule
